// File: rtl/counter_event_syn.sv
// Multi-channel event synchronizer: async inputs pass through a flop chain and an edge detector,
// and each detected event is accumulated in a per-channel saturating pending counter.
module counter_event_syn #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 2,
  parameter int CNT_W       = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [CH-1:0]         i_din,
  input  logic [CH-1:0]         i_evt_ack,
  input  logic [CH-1:0]         i_ovf_clr,
  output logic [CH-1:0]         o_evt_pulse,
  output logic [CH-1:0]         o_evt_valid,
  output logic [CH*CNT_W-1:0]   o_evt_cnt,
  output logic [CH-1:0]         o_evt_ovf
);

  localparam int WARM_LEN = SYNC_STAGES + 1;
  localparam int WARM_W   = $clog2(WARM_LEN + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARM_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // Warm-up counter: edges are ignored until the chain holds post-reset samples only.
  logic [WARM_W-1:0] warm_reg;
  logic [WARM_W-1:0] warm_next;
  logic              armed;

  always_comb begin
    armed     = (warm_reg == WARM_DONE);
    warm_next = armed ? warm_reg : warm_reg + WARM_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) warm_reg <= '0;
    else         warm_reg <= warm_next;
  end

  // Synchronizer chain plus one history stage for edge detection.
  logic [SYNC_STAGES-1:0][CH-1:0] sync_reg;
  logic [CH-1:0]                  hist_reg;
  logic [CH-1:0]                  s_last;
  logic [CH-1:0]                  edge_raw;
  logic [CH-1:0]                  evt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sync_reg <= '0;
      hist_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_din};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign s_last = sync_reg[SYNC_STAGES-1];

  generate
    if (EDGE_MODE == 0) begin : g_rise
      assign edge_raw = s_last & ~hist_reg;
    end else if (EDGE_MODE == 1) begin : g_fall
      assign edge_raw = ~s_last & hist_reg;
    end else begin : g_any
      assign edge_raw = s_last ^ hist_reg;
    end
  endgenerate

  assign evt = armed ? edge_raw : '0;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             ovf_reg;
      logic             ovf_next;
      logic             pulse_reg;
      logic             drop;

      // Event and ack together cancel out, except at zero where the event wins.
      always_comb begin
        cnt_next = cnt_reg;
        drop     = 1'b0;
        case ({evt[gi], i_evt_ack[gi]})
          2'b10: begin
            if (cnt_reg == CNT_MAX) drop = 1'b1;
            else                    cnt_next = cnt_reg + CNT_ONE;
          end
          2'b01: begin
            if (cnt_reg != CNT_ZERO) cnt_next = cnt_reg - CNT_ONE;
          end
          2'b11: begin
            if (cnt_reg == CNT_ZERO) cnt_next = CNT_ONE;
          end
          default: ;
        endcase
        ovf_next = drop | (ovf_reg & ~i_ovf_clr[gi]);
      end

      always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
          cnt_reg   <= '0;
          ovf_reg   <= 1'b0;
          pulse_reg <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          ovf_reg   <= ovf_next;
          pulse_reg <= evt[gi];
        end
      end

      assign o_evt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
      assign o_evt_valid[gi]              = (cnt_reg != CNT_ZERO);
      assign o_evt_pulse[gi]              = pulse_reg;
      assign o_evt_ovf[gi]                = ovf_reg;
    end
  endgenerate

endmodule

// File: tb/tb_counter_event_syn.sv
// Directed and random checks of counter_event_syn against a delay-line and
// integer-counter reference model.
module tb_counter_event_syn;
  localparam int CH    = 4;
  localparam int SYNC  = 2;
  localparam int EDGE  = 2;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic                clk;
  logic                rstn;
  logic [CH-1:0]       din, ack, clr;
  logic [CH-1:0]       o_evt_pulse, o_evt_valid, o_evt_ovf;
  logic [CH*CNT_W-1:0] o_evt_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: sample history (newest first), counts, flags.
  bit [CH-1:0]  hist[$];
  int unsigned  cnt_m[CH];
  bit           ovf_m[CH];
  bit [CH-1:0]  pulse_m;
  int           since_rst;

  counter_event_syn #(
    .CH(CH), .SYNC_STAGES(SYNC), .EDGE_MODE(EDGE), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_din(din),
    .i_evt_ack(ack),
    .i_ovf_clr(clr),
    .o_evt_pulse(o_evt_pulse),
    .o_evt_valid(o_evt_valid),
    .o_evt_cnt(o_evt_cnt),
    .o_evt_ovf(o_evt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference: an input change sampled at edge t becomes an event at edge t+SYNC.
  task automatic model_edge(input logic [CH-1:0] d, input logic [CH-1:0] a,
                            input logic [CH-1:0] c, input logic r);
    bit [CH-1:0] cur, prv, e;
    bit          dropped;
    if (!r) begin
      hist.delete();
      for (int i = 0; i <= SYNC; i++) hist.push_back('0);
      since_rst = 0;
      pulse_m   = '0;
      for (int n = 0; n < CH; n++) begin
        cnt_m[n] = 0;
        ovf_m[n] = 1'b0;
      end
    end else begin
      cur = hist[SYNC-1];
      prv = hist[SYNC];
      case (EDGE)
        0:       e = cur & ~prv;
        1:       e = ~cur & prv;
        default: e = cur ^ prv;
      endcase
      if (since_rst < SYNC + 1) begin
        e = '0;
        since_rst++;
      end
      for (int n = 0; n < CH; n++) begin
        dropped = 1'b0;
        if (e[n] && !a[n]) begin
          if (cnt_m[n] == MAXV) dropped = 1'b1;
          else                  cnt_m[n]++;
        end else if (!e[n] && a[n]) begin
          if (cnt_m[n] > 0) cnt_m[n]--;
        end else if (e[n] && a[n] && cnt_m[n] == 0) begin
          cnt_m[n] = 1;
        end
        ovf_m[n] = dropped ? 1'b1 : (c[n] ? 1'b0 : ovf_m[n]);
      end
      pulse_m = e;
      hist.push_front(d);
      void'(hist.pop_back());
    end
  endtask

  task automatic step(input logic [CH-1:0] d, input logic [CH-1:0] a,
                      input logic [CH-1:0] c, input logic r);
    logic [CH-1:0] v_exp, o_exp;
    din = d; ack = a; clr = c; rstn = r;
    @(posedge clk);
    model_edge(d, a, c, r);
    #1;
    for (int n = 0; n < CH; n++) begin
      v_exp[n] = (cnt_m[n] != 0);
      o_exp[n] = ovf_m[n];
      check($sformatf("cnt%0d", n), 32'(o_evt_cnt[n*CNT_W +: CNT_W]), cnt_m[n]);
    end
    check("pulse", 32'(o_evt_pulse), 32'(pulse_m));
    check("valid", 32'(o_evt_valid), 32'(v_exp));
    check("ovf",   32'(o_evt_ovf),   32'(o_exp));
  endtask

  initial begin
    logic [CH-1:0] d;
    logic [CH-1:0] nd;
    int            tgt[CH];
    int            age[CH];

    // Static-high inputs through reset release never produce events.
    d = '1;
    repeat (3) step(d, '0, '0, 1'b0);
    repeat (20) step(d, '0, '0, 1'b1);
    check("static_cnt",   32'(o_evt_cnt),   32'd0);
    check("static_valid", 32'(o_evt_valid), 32'd0);
    check("static_pulse", 32'(o_evt_pulse), 32'd0);

    d = '0;
    repeat (2) step(d, '0, '0, 1'b0);
    repeat (5) step(d, '0, '0, 1'b1);

    // Ch0 single toggle: pulse and count appear SYNC edges after first sample.
    d[0] = 1'b1;
    step(d, '0, '0, 1'b1);
    check("lat_k0", 32'(o_evt_pulse[0]), 32'd0);
    step(d, '0, '0, 1'b1);
    check("lat_k1", 32'(o_evt_pulse[0]), 32'd0);
    step(d, '0, '0, 1'b1);
    check("lat_pulse", 32'(o_evt_pulse[0]), 32'd1);
    check("lat_cnt",   32'(o_evt_cnt[3:0]), 32'd1);
    check("lat_valid", 32'(o_evt_valid[0]), 32'd1);
    step(d, '0, '0, 1'b1);
    check("lat_once", 32'(o_evt_pulse[0]), 32'd0);

    // Ch1 saturation and overflow clear.
    for (int i = 0; i < 17; i++) begin
      d[1] = ~d[1];
      step(d, '0, '0, 1'b1);
      step(d, '0, '0, 1'b1);
    end
    repeat (3) step(d, '0, '0, 1'b1);
    check("sat_cnt", 32'(o_evt_cnt[7:4]), 32'd15);
    check("sat_ovf", 32'(o_evt_ovf[1]),   32'd1);
    step(d, '0, 4'b0010, 1'b1);
    check("clr_ovf", 32'(o_evt_ovf[1]),   32'd0);
    check("clr_cnt", 32'(o_evt_cnt[7:4]), 32'd15);

    // Ch2 drain past zero.
    for (int i = 0; i < 3; i++) begin
      d[2] = ~d[2];
      step(d, '0, '0, 1'b1);
      step(d, '0, '0, 1'b1);
    end
    repeat (3) step(d, '0, '0, 1'b1);
    check("drain_start", 32'(o_evt_cnt[11:8]), 32'd3);
    repeat (5) step(d, 4'b0100, '0, 1'b1);
    check("drain_cnt",   32'(o_evt_cnt[11:8]), 32'd0);
    check("drain_valid", 32'(o_evt_valid[2]),  32'd0);
    check("drain_ovf",   32'(o_evt_ovf[2]),    32'd0);

    // Ch3 simultaneous event and ack at max and at zero.
    for (int i = 0; i < 15; i++) begin
      d[3] = ~d[3];
      step(d, '0, '0, 1'b1);
      step(d, '0, '0, 1'b1);
    end
    repeat (3) step(d, '0, '0, 1'b1);
    d[3] = ~d[3];
    step(d, '0, '0, 1'b1);
    step(d, '0, '0, 1'b1);
    step(d, 4'b1000, '0, 1'b1);
    check("both_max_pulse", 32'(o_evt_pulse[3]),   32'd1);
    check("both_max_cnt",   32'(o_evt_cnt[15:12]), 32'd15);
    check("both_max_ovf",   32'(o_evt_ovf[3]),     32'd0);
    repeat (16) step(d, 4'b1000, '0, 1'b1);
    check("ch3_empty", 32'(o_evt_cnt[15:12]), 32'd0);
    d[3] = ~d[3];
    step(d, '0, '0, 1'b1);
    step(d, '0, '0, 1'b1);
    step(d, 4'b1000, '0, 1'b1);
    check("both_zero_cnt", 32'(o_evt_cnt[15:12]), 32'd1);

    // Mid-operation reset with counts {5,3,1,15} and ch3 overflowed.
    repeat (2) step(d, '0, '0, 1'b0);
    repeat (5) step(d, '0, '0, 1'b1);
    tgt = '{5, 3, 1, 17};
    for (int i = 0; i < 17; i++) begin
      for (int n = 0; n < CH; n++) if (i < tgt[n]) d[n] = ~d[n];
      step(d, '0, '0, 1'b1);
      step(d, '0, '0, 1'b1);
    end
    repeat (3) step(d, '0, '0, 1'b1);
    check("pre_rst_cnt", 32'(o_evt_cnt), 32'hF135);
    check("pre_rst_ovf", 32'(o_evt_ovf), 32'h8);
    d = ~d;
    step(d, '0, '0, 1'b0);
    check("rst_cnt",   32'(o_evt_cnt),   32'd0);
    check("rst_ovf",   32'(o_evt_ovf),   32'd0);
    check("rst_pulse", 32'(o_evt_pulse), 32'd0);
    check("rst_valid", 32'(o_evt_valid), 32'd0);
    repeat (6) step(d, '0, '0, 1'b1);
    check("warm_cnt", 32'(o_evt_cnt), 32'd0);

    // Random traffic; each input level is held at least two cycles.
    for (int n = 0; n < CH; n++) age[n] = 2;
    for (int t = 0; t < 600; t++) begin
      nd = d;
      for (int n = 0; n < CH; n++) begin
        age[n]++;
        if (age[n] >= 2 && $urandom_range(0, 2) == 0) begin
          nd[n] = ~nd[n];
          age[n] = 0;
        end
      end
      d = nd;
      step(d, CH'($urandom & $urandom),
           ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0,
           ($urandom_range(0, 149) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
